// File: rtl/delta_encoder_multichannel.sv
`default_nettype none
// ============================================================================
// delta_encoder_multichannel: TDM delta-modulation spike encoder, latency 2.
// Optional DM_FIRST_SAMPLE_INIT_EN primes each channel's ref from its first sample.
// Revision: 1.0
// ============================================================================
module delta_encoder_multichannel #(
  parameter int CHANNELS   = 16,
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 3,
  parameter int DELTA_INIT = 16,
  localparam int CH_W      = $clog2(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  input  logic [CH_W-1:0]         in_ch_i,
  input  logic signed [WIDTH-1:0] in_data_i,
  input  logic                    cfg_we_i,
  input  logic [CH_W-1:0]         cfg_ch_i,
  input  logic [WIDTH-2:0]        cfg_delta_i,
  output logic                    out_valid_o,
  output logic [CH_W-1:0]         out_ch_o,
  output logic                    out_pos_o,
  output logic                    out_neg_o,
  output logic [CNT_W-1:0]        out_count_o,
  output logic signed [WIDTH-1:0] out_recon_o
);

  localparam int MAXC = 2**CNT_W - 1;
  localparam int PW   = WIDTH - 1 + CNT_W;
  localparam int CW   = WIDTH + CNT_W;
  localparam logic [CH_W:0] NCH = (CH_W+1)'(CHANNELS);

  logic signed [WIDTH-1:0] ref_q   [CHANNELS];
  logic [WIDTH-2:0]        delta_q [CHANNELS];

  logic                    s1_valid_q;
  logic [CH_W-1:0]         s1_ch_q;
  logic signed [WIDTH-1:0] s1_data_q;
  logic signed [WIDTH-1:0] s1_ref_q;
  logic [WIDTH-2:0]        s1_delta_q;

  logic                    out_valid_q;
  logic [CH_W-1:0]         out_ch_q;
  logic                    out_pos_q;
  logic                    out_neg_q;
  logic [CNT_W-1:0]        out_count_q;
  logic signed [WIDTH-1:0] out_recon_q;

`ifdef DM_FIRST_SAMPLE_INIT_EN
  logic primed_q [CHANNELS];
  logic s1_primed_q;
`endif

  logic                    in_ok_d;
  logic                    cfg_ok_d;
  logic                    fwd_d;
  logic signed [WIDTH:0]   diff_d;
  logic [WIDTH:0]          mag_d;
  logic [CNT_W-1:0]        count_d;
  logic [PW-1:0]           step_d;
  logic signed [WIDTH-1:0] new_ref_d;
  logic                    pos_d;
  logic                    neg_d;

  assign in_ok_d  = in_valid_i && ({1'b0, in_ch_i} < NCH);
  assign cfg_ok_d = cfg_we_i && ({1'b0, cfg_ch_i} < NCH);
  // The sample in stage 1 writes back on the same edge that captures the next read.
  assign fwd_d    = s1_valid_q && (s1_ch_q == in_ch_i);

  always_comb begin
    diff_d  = {s1_data_q[WIDTH-1], s1_data_q} - {s1_ref_q[WIDTH-1], s1_ref_q};
    mag_d   = diff_d[WIDTH] ? $unsigned(-diff_d) : $unsigned(diff_d);
    count_d = '0;
    for (int k = 1; k <= MAXC; k++) begin
      if (CW'(mag_d) > CW'(PW'($unsigned(k)) * PW'(s1_delta_q)))
        count_d = CNT_W'($unsigned(k));
    end
    // Strict compare keeps step below |diff|, so it fits in WIDTH bits.
    step_d    = PW'(count_d) * PW'(s1_delta_q);
    new_ref_d = s1_ref_q;
    pos_d     = 1'b0;
    neg_d     = 1'b0;
    if (count_d != '0) begin
      if (diff_d[WIDTH]) begin
        neg_d     = 1'b1;
        new_ref_d = $signed($unsigned(s1_ref_q) - step_d[WIDTH-1:0]);
      end else begin
        pos_d     = 1'b1;
        new_ref_d = $signed($unsigned(s1_ref_q) + step_d[WIDTH-1:0]);
      end
    end
`ifdef DM_FIRST_SAMPLE_INIT_EN
    if (!s1_primed_q) begin
      count_d   = '0;
      pos_d     = 1'b0;
      neg_d     = 1'b0;
      new_ref_d = s1_data_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ref_q[i]   <= '0;
        delta_q[i] <= (WIDTH-1)'(DELTA_INIT);
`ifdef DM_FIRST_SAMPLE_INIT_EN
        primed_q[i] <= 1'b0;
`endif
      end
`ifdef DM_FIRST_SAMPLE_INIT_EN
      s1_primed_q <= 1'b0;
`endif
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_data_q   <= '0;
      s1_ref_q    <= '0;
      s1_delta_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_pos_q   <= 1'b0;
      out_neg_q   <= 1'b0;
      out_count_q <= '0;
      out_recon_q <= '0;
    end else begin
      if (cfg_ok_d)
        delta_q[cfg_ch_i] <= cfg_delta_i;
      s1_valid_q <= in_ok_d;
      if (in_ok_d) begin
        s1_ch_q    <= in_ch_i;
        s1_data_q  <= in_data_i;
        s1_delta_q <= delta_q[in_ch_i];
        s1_ref_q   <= fwd_d ? new_ref_d : ref_q[in_ch_i];
`ifdef DM_FIRST_SAMPLE_INIT_EN
        s1_primed_q <= fwd_d ? 1'b1 : primed_q[in_ch_i];
`endif
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ref_q[s1_ch_q] <= new_ref_d;
`ifdef DM_FIRST_SAMPLE_INIT_EN
        primed_q[s1_ch_q] <= 1'b1;
`endif
        out_ch_q    <= s1_ch_q;
        out_pos_q   <= pos_d;
        out_neg_q   <= neg_d;
        out_count_q <= count_d;
        out_recon_q <= new_ref_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_pos_o   = out_pos_q;
  assign out_neg_o   = out_neg_q;
  assign out_count_o = out_count_q;
  assign out_recon_o = out_recon_q;

endmodule
`default_nettype wire

// File: tb/tb_delta_encoder_multichannel.sv
`default_nettype none
// Directed-vector bench for delta_encoder_multichannel (6 channels, delta 100).
module tb_delta_encoder_multichannel;

  localparam int NV = 14;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [2:0]         in_ch;
  logic signed [15:0] in_data;
  logic               cfg_we;
  logic [2:0]         cfg_ch;
  logic [14:0]        cfg_delta;
  logic               out_valid;
  logic [2:0]         out_ch;
  logic               out_pos;
  logic               out_neg;
  logic [2:0]         out_count;
  logic signed [15:0] out_recon;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic vld; int ch; int data; logic we; int wch; int wdelta;
    logic ev; int pos; int neg; int cnt; int recon;
  } vec_t;

  vec_t tv [NV];
  int   mref [6];

  delta_encoder_multichannel #(
    .CHANNELS(6), .WIDTH(16), .CNT_W(3), .DELTA_INIT(100)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ch_i(in_ch), .in_data_i(in_data),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_delta_i(cfg_delta),
    .out_valid_o(out_valid), .out_ch_o(out_ch), .out_pos_o(out_pos),
    .out_neg_o(out_neg), .out_count_o(out_count), .out_recon_o(out_recon)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input int ch, input int data,
                              input logic we, input int wch, input int wdelta,
                              input logic ev, input int pos, input int neg,
                              input int cnt, input int recon);
    vec_t v;
    v.vld = vld; v.ch = ch; v.data = data; v.we = we; v.wch = wch; v.wdelta = wdelta;
    v.ev = ev; v.pos = pos; v.neg = neg; v.cnt = cnt; v.recon = recon;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid  = v.vld;
    in_ch     = v.ch[2:0];
    in_data   = v.data[15:0];
    cfg_we    = v.we;
    cfg_ch    = v.wch[2:0];
    cfg_delta = v.wdelta[14:0];
  endtask

  task automatic idle();
    in_valid = 1'b0; in_ch = '0; in_data = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_delta = '0;
  endtask

  initial begin
    int   last_recon;
    int   last_ch;
    int   act;
    int   old;
    vec_t e;

`ifdef DM_FIRST_SAMPLE_INIT_EN
    tv[0]  = mk(1, 0,   250, 0, 0,  0, 1, 0, 0, 0,   250);
    tv[1]  = mk(1, 0,  5000, 0, 0,  0, 1, 1, 0, 7,   950);
    tv[2]  = mk(1, 0,   850, 0, 0,  0, 1, 0, 0, 0,   950);
    tv[3]  = mk(1, 3,   150, 0, 0,  0, 1, 0, 0, 0,   150);
    tv[4]  = mk(1, 3,   300, 0, 0,  0, 1, 1, 0, 1,   250);
    tv[5]  = mk(1, 2,   120, 1, 2, 50, 1, 0, 0, 0,   120);
    tv[6]  = mk(0, 0,     0, 0, 0,  0, 0, 0, 0, 0,     0);
    tv[7]  = mk(1, 2,   220, 0, 0,  0, 1, 1, 0, 1,   170);
    tv[8]  = mk(1, 5, -1234, 0, 0,  0, 1, 0, 0, 0, -1234);
    tv[9]  = mk(1, 5, -1000, 0, 0,  0, 1, 1, 0, 2, -1034);
    tv[12] = mk(1, 1,    37, 0, 0,  0, 1, 0, 0, 0,    37);
    tv[13] = mk(1, 1,    -5, 0, 0,  0, 1, 0, 1, 7,    37);
`else
    tv[0]  = mk(1, 0,   250, 0, 0,  0, 1, 1, 0, 2,   200);
    tv[1]  = mk(1, 0,  5000, 0, 0,  0, 1, 1, 0, 7,   900);
    tv[2]  = mk(1, 0,   850, 0, 0,  0, 1, 0, 0, 0,   900);
    tv[3]  = mk(1, 3,   150, 0, 0,  0, 1, 1, 0, 1,   100);
    tv[4]  = mk(1, 3,   300, 0, 0,  0, 1, 1, 0, 1,   200);
    tv[5]  = mk(1, 2,   120, 1, 2, 50, 1, 1, 0, 1,   100);
    tv[6]  = mk(0, 0,     0, 0, 0,  0, 0, 0, 0, 0,     0);
    tv[7]  = mk(1, 2,   220, 0, 0,  0, 1, 1, 0, 2,   200);
    tv[8]  = mk(1, 5, -1234, 0, 0,  0, 1, 0, 1, 7,  -700);
    tv[9]  = mk(1, 5, -1000, 0, 0,  0, 1, 0, 1, 2,  -900);
    tv[12] = mk(1, 1,    37, 0, 0,  0, 1, 1, 0, 7,     0);
    tv[13] = mk(1, 1,    -5, 0, 0,  0, 1, 0, 1, 7,     0);
`endif
    // Channel 6 is out of range; delta 0 goes to ch1 with no sample.
    tv[10] = mk(1, 6,   999, 0, 0,  0, 0, 0, 0, 0,     0);
    tv[11] = mk(0, 0,     0, 1, 1,  0, 0, 0, 0, 0,     0);

    for (int i = 0; i < 6; i++) mref[i] = 0;

    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_pos",   int'(out_pos),   0);
    chk("rst_neg",   int'(out_neg),   0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_recon", int'(out_recon), 0);
    chk("rst_ch",    int'(out_ch),    0);

    last_recon = 0;
    last_ch    = 0;
    for (int j = 0; j < NV + 2; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        e = tv[j-2];
        chk($sformatf("v%0d_valid", j-2), int'(out_valid), int'(e.ev));
        if (e.ev) begin
          act = int'($signed(out_recon));
          chk($sformatf("v%0d_ch", j-2),    int'(out_ch),    e.ch);
          chk($sformatf("v%0d_pos", j-2),   int'(out_pos),   e.pos);
          chk($sformatf("v%0d_neg", j-2),   int'(out_neg),   e.neg);
          chk($sformatf("v%0d_count", j-2), int'(out_count), e.cnt);
          chk($sformatf("v%0d_recon", j-2), act,             e.recon);
          old = mref[e.ch];
          if (out_count != 0 && act != old)
            chk($sformatf("v%0d_between", j-2),
                int'((old < act && act < e.data) || (e.data < act && act < old)), 1);
          mref[e.ch] = e.recon;
          last_recon = e.recon;
          last_ch    = e.ch;
        end else begin
          chk($sformatf("v%0d_hold_recon", j-2), int'($signed(out_recon)), last_recon);
          chk($sformatf("v%0d_hold_ch", j-2),    int'(out_ch),            last_ch);
        end
      end
      if (j < NV) drive(tv[j]);
      else idle();
    end

    // Reset with samples still in the pipeline.
    @(negedge clk);
    idle(); in_valid = 1'b1; in_ch = 3'd0; in_data = 16'sd1000;
    @(negedge clk);
    in_data = 16'sd2000;
    @(negedge clk);
    idle(); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("flush_valid0", int'(out_valid), 0);
    @(negedge clk);
    chk("flush_valid1", int'(out_valid), 0);
    in_valid = 1'b1; in_ch = 3'd0; in_data = 16'sd250;
    @(negedge clk);
    idle();
    chk("flush_valid2", int'(out_valid), 0);
    @(negedge clk);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_ch",    int'(out_ch),    0);
`ifdef DM_FIRST_SAMPLE_INIT_EN
    chk("post_rst_pos",   int'(out_pos),   0);
    chk("post_rst_count", int'(out_count), 0);
    chk("post_rst_recon", int'($signed(out_recon)), 250);
`else
    chk("post_rst_pos",   int'(out_pos),   1);
    chk("post_rst_count", int'(out_count), 2);
    chk("post_rst_recon", int'($signed(out_recon)), 200);
`endif
    @(negedge clk);
    chk("post_rst_pulse", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delta_encoder_multichannel.md
# delta_encoder_multichannel

Time-multiplexed multichannel delta-modulation spike encoder and the successor of the single-step channel encoder in the SYNtzulu front end. It accepts samples tagged with an explicit channel index, compares each one against a per-channel reconstruction, and emits a polarity plus a multi-step spike count. Per-channel thresholds are run-time writable. The block sits between the sample acquisition/FIFO stage and the spike-routing logic feeding the SNN core.

## Interface
- CHANNELS, 16, number of channels (≥2)
- WIDTH, 16, signed sample width
- CNT_W, 3, spike-count width; MAXC = 2^CNT_W−1
- DELTA_INIT, 16, threshold loaded into every channel at reset
- CH_W, clog2(CHANNELS), channel index width (localparam)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample strobe, one sample per cycle max
- in_ch  in  CH_W  channel of sample; values ≥CHANNELS ignored (no output)
- in_data  in  WIDTH  signed sample
- cfg_we  in  1  threshold write strobe
- cfg_ch  in  CH_W  threshold write channel
- cfg_delta  in  WIDTH−1  unsigned threshold
- out_valid  out  1  result strobe
- out_ch  out  CH_W  channel of result
- out_pos, out_neg  out  1  polarity; never both 1
- out_count  out  CNT_W  number of delta steps taken
- out_recon  out  WIDTH  updated reconstruction

## Operation
- State: ref[CHANNELS] (signed WIDTH), delta[CHANNELS] (unsigned WIDTH−1), register arrays or LUTRAM.
- Reset: ref ← 0, delta ← DELTA_INIT, all outputs 0.
- diff = in_data − ref[ch], computed in WIDTH+1 bits.
- count = largest k in [0, MAXC] with |diff| > k·delta (strict compare; parallel comparison against multiples 1..MAXC, no divider).
- count=0: pos=neg=0, ref unchanged. diff>0: pos=1, ref += count·delta. diff<0: neg=1, ref −= count·delta.
- Invariant (no saturation logic): the new ref always lies strictly between old ref and in_data, so it stays in signed WIDTH range. The bench asserts this.
- delta=0: any nonzero diff gives count=MAXC with ref unchanged.
- out_recon = new ref. out_valid is asserted for every accepted sample, including count=0.
- cfg write: delta[cfg_ch] is updated at the clock edge. A sample accepted in the same cycle on the same channel uses the old delta. Samples accepted later use the new delta.

## Timing
- Pipeline, fixed latency 2. Cycle N: in_valid sampled, ref/delta read. Cycle N+1: diff/count computed and registered. Edge ending N+1: outputs valid in cycle N+2, and ref write-back occurs.
- Full throughput: one sample per cycle, any channel order, no backpressure.
- Hazard: consecutive samples on the same channel (N, N+1), or with a one-cycle gap, must see the forwarded, updated ref. The result must be identical to serial processing.
- out_valid is a single-cycle pulse per sample. The other outputs hold their last value when out_valid=0.
- rst mid-operation: in-flight samples are discarded and out_valid=0 from the cycle after rst. No write-back from discarded samples.

## Configuration
- DM_FIRST_SAMPLE_INIT_EN defined: a per-channel primed bit is cleared on reset. The first accepted sample of an unprimed channel sets ref ← in_data, emits out_valid with pos=neg=0 and count=0, and sets primed. Forwarding also covers primed.
- Not defined: no primed bits. The first sample is compared against ref=0 like any other.

## Test plan
All cases use DELTA_INIT=100, CNT_W=3, WIDTH=16 unless noted.
- Reset, then ch0 sample 250: at N+2, out_pos=1, count=2, recon=200, out_ch=0.
- Follow-up ch0 sample 5000: count=7 (clamped), recon=900. Then ch0 sample 850: out_neg=0, out_pos=0, count=0, recon=900.
- Back-to-back ch3 samples 150 then 300 in consecutive cycles: first gives count=1, recon=100; second gives count=1, recon=200 (forwarded ref, strict compare at 200).
- cfg_we ch2 delta=50 in the same cycle as a ch2 sample of 120: count=1, recon=100. Next ch2 sample 220: count=2, recon=200.
- Macro defined: first ch5 sample −1234 gives no spike, recon=−1234. Next ch5 sample −1000 gives pos, count=2, recon=−1034. Macro undefined: the same −1234 gives neg, count=7, recon=−700.
- Samples in flight on the cycles preceding rst: no out_valid after reset, and a subsequent ch0 sample of 250 reproduces scenario 1. Also, in_ch=CHANNELS produces no out_valid.
